prim_fifo_sync_wm: RTL

- Synchronous single-clock FIFO, next generation of the team's generic sync FIFO.
- Adds: any Depth >= 1, not only powers of two; runtime high/low watermark flags; a high-water-mark occupancy register; a sticky pointer-integrity error.
- Drop-in for peripheral TX/RX buffers that need interrupt thresholds and fault reporting.

---
 rtl/prim_fifo_pkg.sv | 13 +
 rtl/prim_fifo_ptr.sv | 45 ++++
 rtl/prim_fifo_sync_wm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/prim_fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO family.
// Pointer index width is at least one bit, even for a single-entry FIFO.
package prim_fifo_pkg;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return idx_w(depth) + 1;
  endfunction

endpackage

// File: rtl/prim_fifo_ptr.sv
// Wrapping FIFO pointer: index counts 0..Depth-1, phase toggles on wrap.
// Ports: clk_i, rst_ni, clr_i, incr_i -> index_o, phase_o, err_o (index >= Depth).
module prim_fifo_ptr
  import prim_fifo_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned IdxW = idx_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            incr_i,
  output logic [IdxW-1:0] index_o,
  output logic            phase_o,
  output logic            err_o
);

  localparam logic [IdxW-1:0] Last = IdxW'(Depth - 1);
  localparam logic [IdxW:0]   Lim  = (IdxW+1)'(Depth);

  logic [IdxW-1:0] index_q;
  logic            phase_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= '0;
      phase_q <= 1'b0;
    end else if (clr_i) begin
      index_q <= '0;
      phase_q <= 1'b0;
    end else if (incr_i) begin
      if (index_q == Last) begin
        index_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        index_q <= index_q + 1'b1;
      end
    end
  end

  assign index_o = index_q;
  assign phase_o = phase_q;
  assign err_o   = ({1'b0, index_q} >= Lim);

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Single-clock FIFO, any depth, with watermarks, peak occupancy and a sticky pointer error.
// Ports: w{valid,ready,data}, r{valid,ready,data}, clr_i, depth_o, wm_{hi,lo}_{i,o}, max_depth_o, err_o.
module prim_fifo_sync_wm
  import prim_fifo_pkg::*;
#(
  parameter int unsigned Width             = 16,
  parameter int unsigned Depth             = 8,
  parameter bit          Pass              = 1'b1,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  localparam int unsigned DepthW = $clog2(Depth + 1),
  localparam int unsigned PtrW   = ptr_w(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o,
  input  logic [DepthW-1:0] wm_hi_i,
  input  logic [DepthW-1:0] wm_lo_i,
  output logic              wm_hi_o,
  output logic              wm_lo_o,
  output logic [DepthW-1:0] max_depth_o,
  output logic              err_o
);

  if (Depth < 1) begin : g_bad_depth
    $error("prim_fifo_sync_wm: Depth must be >= 1");
  end

  localparam int unsigned IdxW = idx_w(Depth);
  localparam logic [DepthW-1:0] DepthV = DepthW'(Depth);

  logic [IdxW-1:0]   windex, rindex;
  logic              wphase, rphase;
  logic              werr, rerr;
  logic [PtrW-1:0]   wptr, rptr;
  logic [DepthW-1:0] widx, ridx;
  logic              full, fifo_empty;
  logic              wfire, rfire;
  logic [Width-1:0]  mem_rdata, rdata_raw;
  logic [DepthW-1:0] max_q;
  logic              err_q;

  prim_fifo_ptr #(.Depth(Depth)) u_wptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .incr_i  (wfire),
    .index_o (windex),
    .phase_o (wphase),
    .err_o   (werr)
  );

  prim_fifo_ptr #(.Depth(Depth)) u_rptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .incr_i  (rfire),
    .index_o (rindex),
    .phase_o (rphase),
    .err_o   (rerr)
  );

  assign wptr       = {wphase, windex};
  assign rptr       = {rphase, rindex};
  assign full       = (windex == rindex) && (wphase != rphase);
  assign fifo_empty = (wptr == rptr);
  assign widx       = DepthW'(windex);
  assign ridx       = DepthW'(rindex);

  always_comb begin
    depth_o = '0;
    unique case (1'b1)
      full:               depth_o = DepthV;
      (wphase == rphase): depth_o = widx - ridx;
      default:            depth_o = DepthV - ridx + widx;
    endcase
  end

  assign wready_o = ~full;
  assign wfire    = wvalid_i & wready_o;
  assign rvalid_o = Pass ? (~fifo_empty | wvalid_i) : ~fifo_empty;
  assign rfire    = rvalid_o & rready_i;

  // Pass-through: an empty FIFO forwards the incoming word combinationally.
  assign rdata_raw = (Pass && fifo_empty) ? wdata_i : mem_rdata;
  assign rdata_o   = (OutputZeroIfEmpty && !rvalid_o) ? '0 : rdata_raw;

  if (Depth == 1) begin : g_one
    logic [Width-1:0] mem_q;
    always_ff @(posedge clk_i) begin
      if (wfire) mem_q <= wdata_i;
    end
    assign mem_rdata = mem_q;
  end else begin : g_mem
    logic [Width-1:0] mem_q [Depth];
    always_ff @(posedge clk_i) begin
      if (wfire) mem_q[windex] <= wdata_i;
    end
    assign mem_rdata = mem_q[rindex];
  end

  assign wm_hi_o = (depth_o >= wm_hi_i);
  assign wm_lo_o = (depth_o <= wm_lo_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= '0;
    end else if (clr_i) begin
      max_q <= '0;
    end else if (depth_o > max_q) begin
      max_q <= depth_o;
    end
  end

  // Only a reset clears the error; a flush must not hide a corrupted pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | werr | rerr;
  end

  assign max_depth_o = max_q;
  assign err_o       = err_q;

endmodule
